filtro_recursivo_2o: RTL and testbench

Second-order recursive (IIR) filter datapath that consumes the a1/a2/b0/b1/b2 coefficients produced by the coefficient selector multiplexers. It computes y[n] = b0·x[n] + b1·x[n-1] + b2·x[n-2] + a1·y[n-1] − a2·y[n-2] in signed fixed point. A single shared multiplier is time-multiplexed by a small FSM, one sample per request. It sits between the sample source (ADC/sample-tick domain) and the output/DAC stage.

---
 rtl/filtro_recursivo_2o.sv | 163 ++++++++++++++++
 tb/tb_filtro_recursivo_2o.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/filtro_recursivo_2o.sv
// Second-order IIR filter: y = b0*x0 + b1*x1 + b2*x2 + a1*y1 - a2*y2, Q7.14 coefficients.
// One shared multiplier, one product per cycle, sequenced by a small FSM.
module filtro_recursivo_2o #(
  parameter int unsigned Width = 22,
  parameter int unsigned Frac  = 14,
  parameter int unsigned AccW  = 48
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    sample_valid,
  input  logic signed [Width-1:0] x_in,
  input  logic signed [Width-1:0] coef_b0,
  input  logic signed [Width-1:0] coef_b1,
  input  logic signed [Width-1:0] coef_b2,
  input  logic signed [Width-1:0] coef_a1,
  input  logic signed [Width-1:0] coef_a2,
  output logic                    busy,
  output logic signed [Width-1:0] y_out,
  output logic                    y_valid,
  output logic                    overrun
);

  localparam int unsigned ProdW = 2 * Width;
  localparam int unsigned ExtW  = AccW - Width + 1;

  localparam logic signed [AccW-1:0] RoundK = AccW'(1) << (Frac - 1);
  localparam logic signed [AccW-1:0] YMax   = {{ExtW{1'b0}}, {(Width-1){1'b1}}};
  localparam logic signed [AccW-1:0] YMin   = {{ExtW{1'b1}}, {(Width-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    MAC0,
    MAC1,
    MAC2,
    MAC3,
    MAC4,
    OUT
  } state_t;

  state_t state;

  logic signed [Width-1:0] x0, x1, x2, y1, y2;
  logic signed [Width-1:0] cb0, cb1, cb2, ca1, ca2;
  logic signed [AccW-1:0]  acc;

  logic signed [Width-1:0] op_a, op_b;
  logic signed [ProdW-1:0] prod;
  logic signed [AccW-1:0]  prod_ext;
  logic signed [AccW-1:0]  acc_sum;
  logic signed [AccW-1:0]  rnd;
  logic signed [AccW-1:0]  shifted;
  logic signed [Width-1:0] sat_c;

  // Operand select for the shared multiplier
  always_comb begin
    op_a = '0;
    op_b = '0;
    unique case (state)
      MAC0: begin op_a = cb0; op_b = x0; end
      MAC1: begin op_a = cb1; op_b = x1; end
      MAC2: begin op_a = cb2; op_b = x2; end
      MAC3: begin op_a = ca1; op_b = y1; end
      MAC4: begin op_a = ca2; op_b = y2; end
      default: begin op_a = '0; op_b = '0; end
    endcase
  end

  assign prod     = op_a * op_b;
  assign prod_ext = AccW'(prod);
  // The a2 term enters with a negative sign
  assign acc_sum  = (state == MAC4) ? (acc - prod_ext) : (acc + prod_ext);

  // Round half up, then clamp to the output word; the final sum is used directly on the last MAC
  assign rnd     = acc_sum + RoundK;
  assign shifted = rnd >>> Frac;

  always_comb begin
    sat_c = shifted[Width-1:0];
    if (shifted > YMax) begin
      sat_c = {1'b0, {(Width-1){1'b1}}};
    end else if (shifted < YMin) begin
      sat_c = {1'b1, {(Width-1){1'b0}}};
    end
  end

  // Sequencer, history and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      y_out   <= '0;
      y_valid <= 1'b0;
      overrun <= 1'b0;
      acc     <= '0;
      x0      <= '0;
      x1      <= '0;
      x2      <= '0;
      y1      <= '0;
      y2      <= '0;
      cb0     <= '0;
      cb1     <= '0;
      cb2     <= '0;
      ca1     <= '0;
      ca2     <= '0;
    end else begin
      y_valid <= 1'b0;
      if (clear) begin
        state   <= IDLE;
        busy    <= 1'b0;
        overrun <= 1'b0;
        acc     <= '0;
        x0      <= '0;
        x1      <= '0;
        x2      <= '0;
        y1      <= '0;
        y2      <= '0;
      end else begin
        if (sample_valid && (state != IDLE)) begin
          overrun <= 1'b1;
        end
        unique case (state)
          IDLE: begin
            if (sample_valid) begin
              x0    <= x_in;
              cb0   <= coef_b0;
              cb1   <= coef_b1;
              cb2   <= coef_b2;
              ca1   <= coef_a1;
              ca2   <= coef_a2;
              acc   <= '0;
              busy  <= 1'b1;
              state <= MAC0;
            end
          end
          MAC0: begin acc <= acc_sum; state <= MAC1; end
          MAC1: begin acc <= acc_sum; state <= MAC2; end
          MAC2: begin acc <= acc_sum; state <= MAC3; end
          MAC3: begin acc <= acc_sum; state <= MAC4; end
          MAC4: begin
            acc     <= acc_sum;
            y_out   <= sat_c;
            y_valid <= 1'b1;
            x2      <= x1;
            x1      <= x0;
            y2      <= y1;
            y1      <= sat_c;
            state   <= OUT;
          end
          OUT: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_filtro_recursivo_2o.sv
// Directed bench for filtro_recursivo_2o with hand-computed values and a fixed-point reference.
module tb_filtro_recursivo_2o;

  localparam int unsigned W = 22;

  logic                clk = 1'b0;
  logic                reset;
  logic                clear;
  logic                sample_valid;
  logic signed [W-1:0] x_in;
  logic signed [W-1:0] b0, b1, b2, a1, a2;
  logic                busy;
  logic signed [W-1:0] y_out;
  logic                y_valid;
  logic                overrun;

  int checks   = 0;
  int failures = 0;

  longint mx1, mx2, my1, my2;

  filtro_recursivo_2o #(.Width(22), .Frac(14), .AccW(48)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .sample_valid (sample_valid),
    .x_in         (x_in),
    .coef_b0      (b0),
    .coef_b1      (b1),
    .coef_b2      (b2),
    .coef_a1      (a1),
    .coef_a2      (a2),
    .busy         (busy),
    .y_out        (y_out),
    .y_valid      (y_valid),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
  endtask

  task automatic model_step(input longint x, output longint y);
    longint acc, r;
    acc = longint'(b0) * x + longint'(b1) * mx1 + longint'(b2) * mx2
        + longint'(a1) * my1 - longint'(a2) * my2;
    r = (acc + 64'sd8192) >>> 14;
    if (r > 2097151) r = 2097151;
    if (r < -2097152) r = -2097152;
    mx2 = mx1; mx1 = x; my2 = my1; my1 = r;
    y = r;
  endtask

  task automatic set_coefs(input longint cb0, input longint cb1, input longint cb2,
                           input longint ca1, input longint ca2);
    b0 = cb0[W-1:0]; b1 = cb1[W-1:0]; b2 = cb2[W-1:0];
    a1 = ca1[W-1:0]; a2 = ca2[W-1:0];
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_reset();
  endtask

  // One sample through the filter at 7-cycle spacing; returns the DUT output
  task automatic run(input longint x, input string tag, input bit perturb, output longint y);
    longint ye, saved_b0;
    int lat, busy_low;
    model_step(x, ye);
    saved_b0 = longint'(b0);
    sample_valid = 1'b1;
    x_in = x[W-1:0];
    step();
    sample_valid = 1'b0;
    if (perturb) b0 = '0;
    lat = 1;
    busy_low = 0;
    while (!y_valid && lat < 12) begin
      if (!busy) busy_low++;
      step();
      lat++;
    end
    if (!busy) busy_low++;
    check({tag, "_lat"}, longint'(lat), 6);
    check({tag, "_busy"}, longint'(busy_low), 0);
    y = longint'(y_out);
    check({tag, "_model"}, y, ye);
    step();
    check({tag, "_vldpulse"}, longint'(y_valid), 0);
    check({tag, "_idle"}, longint'(busy), 0);
    if (perturb) b0 = saved_b0[W-1:0];
  endtask

  initial begin
    longint y, ye;
    int cnt;
    reset = 1'b0; clear = 1'b0; sample_valid = 1'b0; x_in = '0;
    set_coefs(0, 0, 0, 0, 0);
    model_reset();
    step(); step();
    check("rst_y", longint'(y_out), 0);
    check("rst_vld", longint'(y_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_ovr", longint'(overrun), 0);
    reset = 1'b1;
    step();

    // Passthrough, with b0 changed after acceptance
    set_coefs(16384, 0, 0, 0, 0);
    run(1000, "pass", 1'b1, y);
    check("pass_y", y, 1000);

    // First-order recursion
    do_clear();
    set_coefs(16384, 0, 0, 8192, 0);
    run(16384, "rec0", 1'b0, y); check("rec0_y", y, 16384);
    run(0, "rec1", 1'b0, y);     check("rec1_y", y, 8192);
    run(0, "rec2", 1'b0, y);     check("rec2_y", y, 4096);
    run(0, "rec3", 1'b0, y);     check("rec3_y", y, 2048);

    // Resonant pole pair, 20 outputs against the reference
    do_clear();
    set_coefs(16384, 0, 0, 32702, 16384);
    for (int i = 0; i < 20; i++) begin
      run((i == 0) ? 100 : 0, "res", 1'b0, y);
      if (i == 0) check("res0_y", y, 100);
      if (i == 1) check("res1_y", y, 200);
      if (i == 2) check("res2_y", y, 299);
    end

    // Rounding and saturation
    do_clear();
    set_coefs(8192, 0, 0, 0, 0);
    run(1, "rnd_p", 1'b0, y);  check("rnd_p_y", y, 1);
    run(-1, "rnd_n", 1'b0, y); check("rnd_n_y", y, 0);
    set_coefs(2097151, 0, 0, 0, 0);
    run(2097151, "sat_p", 1'b0, y);  check("sat_p_y", y, 2097151);
    run(-2097152, "sat_n", 1'b0, y); check("sat_n_y", y, -2097152);

    // Overrun: second sample at T+3 is dropped
    do_clear();
    set_coefs(16384, 0, 0, 0, 0);
    model_step(500, ye);
    sample_valid = 1'b1; x_in = 22'sd500;
    step();
    sample_valid = 1'b0;
    step(); step();
    sample_valid = 1'b1; x_in = 22'sd777;
    step();
    sample_valid = 1'b0;
    check("ovr_flag", longint'(overrun), 1);
    step(); step();
    check("ovr_vld", longint'(y_valid), 1);
    check("ovr_y", longint'(y_out), 500);
    step();
    check("ovr_vldpulse", longint'(y_valid), 0);
    check("ovr_sticky", longint'(overrun), 1);

    // Clear: overrun drops, y_out held, history zeroed
    do_clear();
    check("clr_ovr", longint'(overrun), 0);
    check("clr_busy", longint'(busy), 0);
    check("clr_yhold", longint'(y_out), 500);
    check("clr_vld", longint'(y_valid), 0);
    set_coefs(16384, 16384, 0, 8192, 0);
    run(200, "clr0", 1'b0, y); check("clr0_y", y, 200);
    run(0, "clr1", 1'b0, y);   check("clr1_y", y, 300);

    // Reset in mid-operation
    set_coefs(16384, 0, 0, 0, 0);
    sample_valid = 1'b1; x_in = 22'sd1234;
    step();
    x_in = 22'sd55;
    step();
    sample_valid = 1'b0;
    check("mid_ovr_pre", longint'(overrun), 1);
    step();
    reset = 1'b0;
    #1;
    check("mid_y", longint'(y_out), 0);
    check("mid_busy", longint'(busy), 0);
    check("mid_ovr", longint'(overrun), 0);
    check("mid_vld", longint'(y_valid), 0);
    cnt = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (y_valid) cnt++;
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (y_valid) cnt++;
    end
    check("mid_novld", longint'(cnt), 0);
    check("mid_y_post", longint'(y_out), 0);
    model_reset();
    run(1000, "post", 1'b0, y);
    check("post_y", y, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
